// File: rtl/can_frame_fifo_if.sv
// Read-side bundle of the CAN frame FIFO.
// The master drives the head entry and frame_valid; the slave returns frame_ready.
//   frame_valid  : FIFO non-empty, head entry is on the frame_* signals
//   frame_ready  : reader accepts the head entry this cycle
//   frame_id     : 29-bit ID, standard IDs right-aligned
//   frame_ide    : extended-frame flag
//   frame_rtr    : remote-frame flag
//   frame_dlc    : raw received DLC
//   frame_data   : byte k at [8k+7:8k], bytes not received read 0
//   frame_crc_ok : computed CRC matched the received CRC
interface can_frame_fifo_if #(
    parameter int MAX_BYTES = 8
);
    logic                   frame_valid;
    logic                   frame_ready;
    logic [28:0]            frame_id;
    logic                   frame_ide;
    logic                   frame_rtr;
    logic [3:0]             frame_dlc;
    logic [8*MAX_BYTES-1:0] frame_data;
    logic                   frame_crc_ok;

    modport master (
        output frame_valid, frame_id, frame_ide, frame_rtr, frame_dlc, frame_data, frame_crc_ok,
        input  frame_ready
    );

    modport slave (
        input  frame_valid, frame_id, frame_ide, frame_rtr, frame_dlc, frame_data, frame_crc_ok,
        output frame_ready
    );
endinterface

// File: rtl/can_frame_fifo.sv
// CAN frame parser with CRC-15 check feeding a DEPTH-entry frame FIFO.
// Ports:
//   clk, rst          : system clock, asynchronous active-high reset
//   bit_en            : per-bit strobe qualifying rx and stuff_err
//   rx                : unstuffed CAN bit (0 = dominant)
//   stuff_err         : stuff violation from the unstuffer
//   fr                : read-side handshake and head entry (master modport)
//   frame_err         : one-cycle pulse when a frame is aborted
//   overflow          : one-cycle pulse when a complete frame is dropped (FIFO full)
//   drop_count        : saturating count of overflow drops
//   fifo_count        : entries currently held
module can_frame_fifo #(
    parameter int          DEPTH     = 4,
    parameter int          MAX_BYTES = 8,
    parameter int          EXT_EN    = 1,
    parameter logic [14:0] CRC_POLY  = 15'h4599
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bit_en,
    input  logic                     rx,
    input  logic                     stuff_err,
    can_frame_fifo_if.master         fr,
    output logic                     frame_err,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = 8 * MAX_BYTES;

    typedef enum logic [3:0] {
        IDLE, ID_A, SRR_RTR, IDE, ID_B, RTR, R1, R0, DLC, DATA, CRC, CRC_DEL, WAIT_IDLE
    } state_t;

    typedef struct packed {
        logic [28:0]   id;
        logic          ide;
        logic          rtr;
        logic [3:0]    dlc;
        logic [DW-1:0] data;
        logic          crc_ok;
    } entry_t;

    // One CRC-15 step, MSB first, implicit x^15 term.
    function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
        logic nxt;
        nxt = b ^ crc[14];
        return {crc[13:0], 1'b0} ^ (nxt ? CRC_POLY : 15'h0000);
    endfunction

    state_t        state_r;
    logic [5:0]    cnt_r;
    logic [14:0]   crc_r;
    logic [14:0]   crc_rx_r;
    logic [28:0]   id_r;
    logic          ide_r;
    logic          rtr_r;
    logic [3:0]    dlc_r;
    logic [63:0]   data_r;
    logic [2:0]    last_byte_r;
    logic          crc_ok_r;
    logic          push_r;
    logic          frame_err_r;

    logic [3:0]    dlc_nxt_s;
    logic [2:0]    last_byte_s;
    logic [14:0]   crc_nxt_s;

    assign dlc_nxt_s   = {dlc_r[2:0], rx};
    // DLC 8..15 all mean eight bytes; 1..7 give the byte index of the last byte.
    assign last_byte_s = dlc_nxt_s[3] ? 3'd7 : (dlc_nxt_s[2:0] - 3'd1);
    assign crc_nxt_s   = crc15_step(crc_r, rx);

    // Frame parser: advances only on bit_en, emits push/frame_err pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 6'd0;
            crc_r       <= 15'd0;
            crc_rx_r    <= 15'd0;
            id_r        <= 29'd0;
            ide_r       <= 1'b0;
            rtr_r       <= 1'b0;
            dlc_r       <= 4'd0;
            data_r      <= 64'd0;
            last_byte_r <= 3'd0;
            crc_ok_r    <= 1'b0;
            push_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            push_r      <= 1'b0;
            frame_err_r <= 1'b0;
            if (bit_en) begin
                if (stuff_err && (state_r != IDLE) && (state_r != WAIT_IDLE)) begin
                    frame_err_r <= 1'b1;
                    cnt_r       <= 6'd0;
                    state_r     <= WAIT_IDLE;
                end else begin
                    case (state_r)
                        IDLE: begin
                            if (!rx) begin
                                crc_r    <= crc15_step(15'd0, rx);
                                crc_rx_r <= 15'd0;
                                id_r     <= 29'd0;
                                ide_r    <= 1'b0;
                                rtr_r    <= 1'b0;
                                dlc_r    <= 4'd0;
                                data_r   <= 64'd0;
                                cnt_r    <= 6'd0;
                                state_r  <= ID_A;
                            end
                        end
                        ID_A: begin
                            crc_r <= crc_nxt_s;
                            id_r  <= {id_r[27:0], rx};
                            if (cnt_r == 6'd10) begin
                                cnt_r   <= 6'd0;
                                state_r <= SRR_RTR;
                            end else begin
                                cnt_r <= cnt_r + 6'd1;
                            end
                        end
                        SRR_RTR: begin
                            // RTR for a standard frame; overwritten later by the real RTR if extended.
                            crc_r   <= crc_nxt_s;
                            rtr_r   <= rx;
                            state_r <= IDE;
                        end
                        IDE: begin
                            crc_r <= crc_nxt_s;
                            if (!rx) begin
                                state_r <= R0;
                            end else if (EXT_EN != 0) begin
                                ide_r   <= 1'b1;
                                cnt_r   <= 6'd0;
                                state_r <= ID_B;
                            end else begin
                                frame_err_r <= 1'b1;
                                cnt_r       <= 6'd0;
                                state_r     <= WAIT_IDLE;
                            end
                        end
                        ID_B: begin
                            crc_r <= crc_nxt_s;
                            id_r  <= {id_r[27:0], rx};
                            if (cnt_r == 6'd17) begin
                                cnt_r   <= 6'd0;
                                state_r <= RTR;
                            end else begin
                                cnt_r <= cnt_r + 6'd1;
                            end
                        end
                        RTR: begin
                            crc_r   <= crc_nxt_s;
                            rtr_r   <= rx;
                            state_r <= R1;
                        end
                        R1: begin
                            crc_r   <= crc_nxt_s;
                            state_r <= R0;
                        end
                        R0: begin
                            crc_r   <= crc_nxt_s;
                            cnt_r   <= 6'd0;
                            state_r <= DLC;
                        end
                        DLC: begin
                            crc_r <= crc_nxt_s;
                            dlc_r <= dlc_nxt_s;
                            if (cnt_r == 6'd3) begin
                                cnt_r       <= 6'd0;
                                last_byte_r <= last_byte_s;
                                state_r     <= (rtr_r || (dlc_nxt_s == 4'd0)) ? CRC : DATA;
                            end else begin
                                cnt_r <= cnt_r + 6'd1;
                            end
                        end
                        DATA: begin
                            crc_r <= crc_nxt_s;
                            // Bytes arrive MSB first; bytes past MAX_BYTES only feed the CRC.
                            if ({1'b0, cnt_r[5:3]} < 4'(MAX_BYTES)) begin
                                data_r[{cnt_r[5:3], ~cnt_r[2:0]}] <= rx;
                            end
                            if (cnt_r == {last_byte_r, 3'b111}) begin
                                cnt_r   <= 6'd0;
                                state_r <= CRC;
                            end else begin
                                cnt_r <= cnt_r + 6'd1;
                            end
                        end
                        CRC: begin
                            crc_rx_r <= {crc_rx_r[13:0], rx};
                            if (cnt_r == 6'd14) begin
                                cnt_r   <= 6'd0;
                                state_r <= CRC_DEL;
                            end else begin
                                cnt_r <= cnt_r + 6'd1;
                            end
                        end
                        CRC_DEL: begin
                            if (rx) begin
                                push_r   <= 1'b1;
                                crc_ok_r <= (crc_r == crc_rx_r);
                            end else begin
                                frame_err_r <= 1'b1;
                            end
                            cnt_r   <= 6'd0;
                            state_r <= WAIT_IDLE;
                        end
                        WAIT_IDLE: begin
                            if (!rx) begin
                                cnt_r <= 6'd0;
                            end else if (cnt_r == 6'd9) begin
                                cnt_r   <= 6'd0;
                                state_r <= IDLE;
                            end else begin
                                cnt_r <= cnt_r + 6'd1;
                            end
                        end
                        default: begin
                            cnt_r   <= 6'd0;
                            state_r <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

    entry_t          in_entry_s;
    entry_t          mem_r [DEPTH];
    entry_t          head_r;
    logic            valid_r;
    logic            overflow_r;
    logic [7:0]      drop_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW-1:0]   rd_nxt_s;
    logic [AW:0]     count_r;
    logic [AW:0]     count_nxt_s;
    logic            full_s;
    logic            pop_s;
    logic            wr_en_s;

    assign in_entry_s = '{id: id_r, ide: ide_r, rtr: rtr_r, dlc: dlc_r,
                          data: data_r[DW-1:0], crc_ok: crc_ok_r};
    assign full_s     = (count_r == (AW+1)'(DEPTH));
    assign pop_s      = valid_r && fr.frame_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en_s    = push_r && (!full_s || pop_s);
    assign rd_nxt_s   = rd_ptr_r + AW'(1);
    assign count_nxt_s = count_r + (AW+1)'(wr_en_s) - (AW+1)'(pop_s);

    // Entry storage; contents are don't-care until written, pointers carry validity.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= in_entry_s;
        end
    end

    // Pointers, occupancy, registered head entry and overflow accounting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            head_r     <= '0;
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
            drop_r     <= 8'd0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_nxt_s;
            end
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != '0);
            // The new head bypasses memory when the FIFO is (or becomes) empty.
            if (pop_s) begin
                head_r <= (count_r == (AW+1)'(1)) ? in_entry_s : mem_r[rd_nxt_s];
            end else if ((count_r == '0) && wr_en_s) begin
                head_r <= in_entry_s;
            end
            overflow_r <= push_r && full_s && !pop_s;
            if (push_r && full_s && !pop_s && (drop_r != 8'hFF)) begin
                drop_r <= drop_r + 8'd1;
            end
        end
    end

    assign fr.frame_valid  = valid_r;
    assign fr.frame_id     = head_r.id;
    assign fr.frame_ide    = head_r.ide;
    assign fr.frame_rtr    = head_r.rtr;
    assign fr.frame_dlc    = head_r.dlc;
    assign fr.frame_data   = head_r.data;
    assign fr.frame_crc_ok = head_r.crc_ok;
    assign frame_err       = frame_err_r;
    assign overflow        = overflow_r;
    assign drop_count      = drop_r;
    assign fifo_count      = count_r;
endmodule

// File: tb/tb_can_frame_fifo.sv
// Directed bench for can_frame_fifo: builds unstuffed CAN bit streams with a
// reference CRC-15, drives them one bit per strobe and checks the queued frames.
module tb_can_frame_fifo;
    logic       clk = 1'b0;
    logic       rst, bit_en, rx, stuff_err;
    logic       frame_err, overflow;
    logic [7:0] drop_count;
    logic [2:0] fifo_count;
    logic       ne_err, ne_ovf;
    logic [7:0] ne_drop;
    logic [2:0] ne_count;

    can_frame_fifo_if #(.MAX_BYTES(8)) fr_if ();
    can_frame_fifo_if #(.MAX_BYTES(8)) ne_if ();
    assign ne_if.frame_ready = 1'b1;

    can_frame_fifo #(.DEPTH(4), .MAX_BYTES(8), .EXT_EN(1), .CRC_POLY(15'h4599)) dut (
        .clk(clk), .rst(rst), .bit_en(bit_en), .rx(rx), .stuff_err(stuff_err),
        .fr(fr_if), .frame_err(frame_err), .overflow(overflow),
        .drop_count(drop_count), .fifo_count(fifo_count));

    can_frame_fifo #(.DEPTH(4), .MAX_BYTES(8), .EXT_EN(0), .CRC_POLY(15'h4599)) dut_ne (
        .clk(clk), .rst(rst), .bit_en(bit_en), .rx(rx), .stuff_err(stuff_err),
        .fr(ne_if), .frame_err(ne_err), .overflow(ne_ovf),
        .drop_count(ne_drop), .fifo_count(ne_count));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int err_cnt = 0;
    int ovf_cnt = 0;
    int ne_err_cnt = 0;
    int ne_pop_cnt = 0;
    logic fq[$];
    int data_start;
    int del_idx;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_err) err_cnt <= err_cnt + 1;
        if (overflow) ovf_cnt <= ovf_cnt + 1;
        if (ne_err) ne_err_cnt <= ne_err_cnt + 1;
        if (ne_if.frame_valid) ne_pop_cnt <= ne_pop_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] ref_crc_step(input logic [14:0] c, input logic b);
        logic nxt;
        nxt = b ^ c[14];
        return {c[13:0], 1'b0} ^ (nxt ? 15'h4599 : 15'h0000);
    endfunction

    // Assemble SOF..CRC delimiter plus tail recessive bits into fq.
    task automatic make_frame(input logic [28:0] id, input logic ide, input logic rtr,
                              input logic [3:0] dlc, input logic [63:0] data,
                              input int crc_flip, input logic del, input int tail);
        logic [14:0] c;
        int nb;
        fq.delete();
        c = 15'd0;
        fq.push_back(1'b0);
        if (!ide) begin
            for (int i = 10; i >= 0; i--) fq.push_back(id[i]);
            fq.push_back(rtr); fq.push_back(1'b0); fq.push_back(1'b0);
        end else begin
            for (int i = 28; i >= 18; i--) fq.push_back(id[i]);
            fq.push_back(1'b1); fq.push_back(1'b1);
            for (int i = 17; i >= 0; i--) fq.push_back(id[i]);
            fq.push_back(rtr); fq.push_back(1'b0); fq.push_back(1'b0);
        end
        for (int i = 3; i >= 0; i--) fq.push_back(dlc[i]);
        data_start = fq.size();
        nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        for (int k = 0; k < nb; k++)
            for (int i = 7; i >= 0; i--) fq.push_back(data[8*k+i]);
        foreach (fq[j]) c = ref_crc_step(c, fq[j]);
        if (crc_flip >= 0) c[crc_flip] = ~c[crc_flip];
        for (int i = 14; i >= 0; i--) fq.push_back(c[i]);
        del_idx = fq.size();
        fq.push_back(del);
        repeat (tail) fq.push_back(1'b1);
    endtask

    task automatic send_bit(input logic b, input logic se);
        @(negedge clk);
        rx = b; bit_en = 1'b1; stuff_err = se;
        @(negedge clk);
        bit_en = 1'b0; stuff_err = 1'b0;
    endtask

    task automatic send_frame(input int serr_idx, input bit pop_at_del);
        for (int j = 0; j < fq.size(); j++) begin
            send_bit(fq[j], j == serr_idx);
            if (pop_at_del && j == del_idx) begin
                fr_if.frame_ready = 1'b1;
                @(negedge clk);
                fr_if.frame_ready = 1'b0;
            end
        end
    endtask

    task automatic pop_one();
        @(negedge clk);
        fr_if.frame_ready = 1'b1;
        @(negedge clk);
        fr_if.frame_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bit_en = 1'b0; rx = 1'b1; stuff_err = 1'b0;
        fr_if.frame_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", fr_if.frame_valid, 1'b0);
        check("rst_count", fifo_count, 3'd0);
        check("rst_drop", drop_count, 8'd0);
        check("rst_id", fr_if.frame_id, 29'd0);
        check("rst_err", frame_err, 1'b0);

        // Standard data frame 0x123, DLC 2, AB CD
        make_frame(29'h123, 1'b0, 1'b0, 4'd2, 64'hCDAB, -1, 1'b1, 12);
        send_frame(-1, 0);
        check("std_valid", fr_if.frame_valid, 1'b1);
        check("std_id", fr_if.frame_id, 29'h123);
        check("std_ide", fr_if.frame_ide, 1'b0);
        check("std_rtr", fr_if.frame_rtr, 1'b0);
        check("std_dlc", fr_if.frame_dlc, 4'd2);
        check("std_data", fr_if.frame_data, 64'h0000_0000_0000_CDAB);
        check("std_crc_ok", fr_if.frame_crc_ok, 1'b1);
        check("std_count", fifo_count, 3'd1);
        check("ne_std_pop", ne_pop_cnt, 1);
        pop_one();
        @(negedge clk);
        check("std_pop_count", fifo_count, 3'd0);
        check("std_pop_valid", fr_if.frame_valid, 1'b0);

        // Extended frame 0x12345678, DLC 15, bytes 01..08
        make_frame(29'h12345678, 1'b1, 1'b0, 4'd15, 64'h0807060504030201, -1, 1'b1, 12);
        send_frame(-1, 0);
        check("ext_ide", fr_if.frame_ide, 1'b1);
        check("ext_id", fr_if.frame_id, 29'h12345678);
        check("ext_dlc", fr_if.frame_dlc, 4'd15);
        check("ext_data", fr_if.frame_data, 64'h0807060504030201);
        check("ext_crc_ok", fr_if.frame_crc_ok, 1'b1);
        check("noext_err", ne_err_cnt, 1);
        check("noext_nopush", ne_pop_cnt, 1);
        pop_one();

        // Remote frame 0x7FF, DLC 4: no data field on the wire
        make_frame(29'h7FF, 1'b0, 1'b1, 4'd4, 64'h0, -1, 1'b1, 12);
        send_frame(-1, 0);
        check("rtr_valid", fr_if.frame_valid, 1'b1);
        check("rtr_rtr", fr_if.frame_rtr, 1'b1);
        check("rtr_dlc", fr_if.frame_dlc, 4'd4);
        check("rtr_data", fr_if.frame_data, 64'h0);
        check("rtr_crc_ok", fr_if.frame_crc_ok, 1'b1);
        pop_one();

        // Data frame with one CRC bit flipped
        make_frame(29'h7FF, 1'b0, 1'b0, 4'd4, 64'h44332211, 3, 1'b1, 12);
        send_frame(-1, 0);
        check("badcrc_valid", fr_if.frame_valid, 1'b1);
        check("badcrc_data", fr_if.frame_data, 64'h44332211);
        check("badcrc_crc_ok", fr_if.frame_crc_ok, 1'b0);
        pop_one();
        @(negedge clk);
        check("empty_before_ovf", fifo_count, 3'd0);

        // Five frames into a 4-deep FIFO with no reader
        for (int f = 1; f <= 5; f++) begin
            make_frame(29'(f), 1'b0, 1'b0, 4'd1, 64'(f), -1, 1'b1, 12);
            send_frame(-1, 0);
        end
        check("ovf_count", fifo_count, 3'd4);
        check("ovf_pulses", ovf_cnt, 1);
        check("ovf_drop", drop_count, 8'd1);
        for (int f = 1; f <= 4; f++) begin
            check("drain_order", fr_if.frame_id, 29'(f));
            fr_if.frame_ready = 1'b1;
            @(negedge clk);
        end
        check("drain_valid", fr_if.frame_valid, 1'b0);
        check("drain_count", fifo_count, 3'd0);
        fr_if.frame_ready = 1'b0;

        // Push and pop in the same cycle while full
        for (int f = 16; f <= 19; f++) begin
            make_frame(29'(f), 1'b0, 1'b0, 4'd1, 64'(f), -1, 1'b1, 12);
            send_frame(-1, 0);
        end
        check("full_count", fifo_count, 3'd4);
        make_frame(29'h14, 1'b0, 1'b0, 4'd1, 64'h14, -1, 1'b1, 12);
        send_frame(-1, 1);
        check("pushpop_count", fifo_count, 3'd4);
        check("pushpop_no_ovf", ovf_cnt, 1);
        check("pushpop_drop", drop_count, 8'd1);
        for (int f = 17; f <= 20; f++) begin
            check("pushpop_order", fr_if.frame_id, 29'(f));
            fr_if.frame_ready = 1'b1;
            @(negedge clk);
        end
        fr_if.frame_ready = 1'b0;
        check("pushpop_empty", fifo_count, 3'd0);

        // stuff_err on the third data bit
        make_frame(29'h055, 1'b0, 1'b0, 4'd1, 64'hA5, -1, 1'b1, 12);
        send_frame(data_start + 2, 0);
        check("stuff_err_pulse", err_cnt, 1);
        check("stuff_nopush", fifo_count, 3'd0);

        // Frame starting before 10 recessive bits is ignored
        make_frame(29'h100, 1'b0, 1'b0, 4'd1, 64'h11, -1, 1'b1, 5);
        send_frame(-1, 0);
        make_frame(29'h200, 1'b0, 1'b0, 4'd1, 64'h22, -1, 1'b1, 12);
        send_frame(-1, 0);
        make_frame(29'h300, 1'b0, 1'b0, 4'd1, 64'h33, -1, 1'b1, 12);
        send_frame(-1, 0);
        check("idle_count", fifo_count, 3'd2);
        check("idle_first", fr_if.frame_id, 29'h100);
        pop_one();
        @(negedge clk);
        check("idle_second", fr_if.frame_id, 29'h300);
        check("idle_second_data", fr_if.frame_data, 64'h33);
        check("idle_second_crc", fr_if.frame_crc_ok, 1'b1);
        pop_one();

        // CRC delimiter dominant
        make_frame(29'h321, 1'b0, 1'b0, 4'd2, 64'h5A5A, -1, 1'b0, 12);
        send_frame(-1, 0);
        check("crcdel_err", err_cnt, 2);
        check("crcdel_nopush", fifo_count, 3'd0);

        // Reset mid-DATA with two entries queued
        make_frame(29'h0A, 1'b0, 1'b0, 4'd1, 64'h0A, -1, 1'b1, 12);
        send_frame(-1, 0);
        make_frame(29'h0B, 1'b0, 1'b0, 4'd1, 64'h0B, -1, 1'b1, 12);
        send_frame(-1, 0);
        check("prerst_count", fifo_count, 3'd2);
        make_frame(29'h0C, 1'b0, 1'b0, 4'd2, 64'hBEEF, -1, 1'b1, 12);
        for (int j = 0; j <= data_start + 5; j++) send_bit(fq[j], 1'b0);
        rx = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", fr_if.frame_valid, 1'b0);
        check("midrst_count", fifo_count, 3'd0);
        check("midrst_id", fr_if.frame_id, 29'd0);
        check("midrst_data", fr_if.frame_data, 64'h0);
        check("midrst_dlc", fr_if.frame_dlc, 4'd0);
        check("midrst_drop", drop_count, 8'd0);
        rst = 1'b0;
        @(negedge clk);
        make_frame(29'h6E5, 1'b0, 1'b0, 4'd3, 64'h332211, -1, 1'b1, 12);
        send_frame(-1, 0);
        check("postrst_count", fifo_count, 3'd1);
        check("postrst_id", fr_if.frame_id, 29'h6E5);
        check("postrst_dlc", fr_if.frame_dlc, 4'd3);
        check("postrst_data", fr_if.frame_data, 64'h332211);
        check("postrst_crc_ok", fr_if.frame_crc_ok, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/can_frame_fifo.md
Name: can_frame_fifo

Overview:
- Parametrised successor to the single-register CAN packet capture.
- Runs on one system clock. Consumes the unstuffed bit stream, qualified by a per-bit strobe, from the CAN unstuffer.
- Parses standard and, optionally, extended data/remote frames with DLC-driven length, and checks the CRC-15.
- Queues each decoded frame in a DEPTH-entry FIFO. The SPI inspection logic or a host-side reader drains it over a valid/ready handshake.

Parameters:
- DEPTH, 4, number of frame entries in the FIFO; power of two, 2..16.
- MAX_BYTES, 8, data bytes stored per frame, 1..8. Received bytes beyond MAX_BYTES are consumed but not stored.
- EXT_EN, 1, 1 = accept 29-bit extended IDs; 0 = frames with IDE=1 are aborted as errors.
- CRC_POLY, 15'h4599, CRC-15 generator polynomial, implicit x^15 term.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- bit_en  in  1  one-cycle strobe; rx and stuff_err are sampled only when bit_en=1.
- rx  in  1  unstuffed CAN bit, 0 = dominant.
- stuff_err  in  1  stuff violation reported by the unstuffer, qualified by bit_en.
- frame_valid  out  1  FIFO non-empty; head entry is on the frame_* outputs.
- frame_ready  in  1  reader accepts head entry.
- frame_id  out  29  ID; standard IDs right-aligned, bits 28:11 = 0.
- frame_ide  out  1  extended-frame flag.
- frame_rtr  out  1  remote-frame flag.
- frame_dlc  out  4  raw received DLC.
- frame_data  out  8*MAX_BYTES  byte0 at [7:0], byte k at [8k+7:8k]; bytes not received read 0.
- frame_crc_ok  out  1  computed CRC equals received CRC.
- frame_err  out  1  one-cycle pulse: stuff, form or IDE-disabled error aborted a frame.
- overflow  out  1  one-cycle pulse: a complete frame was dropped because the FIFO was full.
- drop_count  out  8  saturating count of overflow drops.
- fifo_count  out  clog2(DEPTH)+1  entries currently held.

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in IDLE, drop_count 0. Reset asserted mid-frame discards the partial frame and the FIFO contents.
- All FSM and shift activity advances only on cycles with bit_en=1. Counters are bit counters.
- FSM states and transitions:
  - IDLE: rx=0 is SOF; clear the CRC register and data, then fold SOF into the CRC → ID_A.
  - ID_A: 11 bits, MSB first → SRR_RTR.
  - SRR_RTR: captured as RTR for standard frames → IDE.
  - IDE: if 0 → R0. If 1 and EXT_EN=1 → ID_B. If 1 and EXT_EN=0 → error.
  - ID_B: 18 bits, appended below the ID_A bits → RTR.
  - RTR → R1 → R0.
  - R0 → DLC.
  - DLC: 4 bits.
  - DATA: nbytes = RTR ? 0 : min(DLC,8). If nbytes=0, skip DATA → CRC.
  - CRC: 15 bits.
  - CRC_DEL: rx must be 1, else error. On success, push the entry → WAIT_IDLE.
  - WAIT_IDLE: returns to IDLE after 10 consecutive recessive bits; any dominant bit restarts the count.
- Byte storage: only bytes with index < MAX_BYTES are stored; the remainder are still fed to the CRC. frame_dlc holds the raw DLC (9..15 allowed).
- CRC: computed over SOF through the last data bit, MSB first. Each step: nxt = rx ^ crc[14]; crc = {crc[13:0],0} ^ (nxt ? CRC_POLY : 0). frame_crc_ok = (crc == received). Frames with a bad CRC are still pushed, with crc_ok=0.
- Errors:
  - stuff_err=1 with bit_en in any state other than IDLE/WAIT_IDLE, a form error at CRC_DEL, or IDE with EXT_EN=0: pulse frame_err, no push → WAIT_IDLE.
  - stuff_err in IDLE or WAIT_IDLE is ignored.
- FIFO read side:
  - Head entry is registered and stable while frame_valid=1.
  - Pop occurs on frame_valid && frame_ready.
  - Output is first-word-fall-through: a push into an empty FIFO gives frame_valid=1 on the next cycle.
- FIFO push/pop collisions:
  - Push when full and no pop in the same cycle: drop the frame, pulse overflow, increment drop_count (saturates at 255).
  - Push and pop in the same cycle when full: both succeed, fifo_count unchanged.
  - Pointers wrap modulo DEPTH.

Test Plan:
- Standard frame, ID 0x123, DLC 2, data AB CD, correct CRC → frame_valid, id=0x123, ide=0, rtr=0, dlc=2, data[15:0]=0xCDAB, higher bytes 0, crc_ok=1, fifo_count=1.
- Extended frame, ID 0x12345678, DLC 15, 8 bytes 01..08 → ide=1, id=0x12345678, dlc=15, data=0x0807060504030201, crc_ok=1. Same frame with EXT_EN=0 → frame_err pulse, no push.
- Remote frame, ID 0x7FF, DLC 4 → rtr=1, data=0, state goes straight from DLC to CRC. Same data frame with one CRC bit flipped → pushed with crc_ok=0.
- DEPTH=4: 5 good frames with frame_ready=0 → fifo_count=4, one overflow pulse, drop_count=1. Then hold ready=1 → first four frames pop in arrival order. Push and pop in the same cycle while full → count stays 4.
- stuff_err during the third data bit → frame_err pulse, no push. A frame starting before 10 recessive bits is ignored; the next frame after 10 recessive bits is captured correctly. CRC_DEL driven 0 → frame_err.
- Assert rst mid-DATA with 2 entries queued → all outputs 0, fifo_count=0. The next frame after release is captured correctly.
